pwm_capture: RTL

PWM capture block: the receive-side counterpart of the PWM generator. Samples an asynchronous PWM input and measures, in `clk` cycles, the high time and full period of each PWM cycle (rising edge to rising edge). Each completed measurement is presented with a one-cycle valid strobe. Stuck-high and stuck-low (0 %/100 % duty) inputs are reported through a timeout flag. It sits next to the generator in the top level, so a generated waveform can be looped back and checked, or an external PWM decoded.

---
 rtl/pwm_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM input and measures the high time and
// period of each cycle (rising edge to rising edge), flagging stuck-high/stuck-low inputs.
module pwm_capture #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  output logic [W-1:0] duty_o,
  output logic [W-1:0] period_o,
  output logic         valid_o,
  output logic         timeout_o,
  output logic         level_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  localparam logic [W-1:0] CntMax  = {W{1'b1}};
  localparam logic [W-1:0] CntOne  = W'(1);
  localparam logic [W-1:0] CntZero = '0;

  logic         s1_q, s1_d;
  logic         pwm_s_q, pwm_s_d;
  logic         pwm_d_q, pwm_d_d;
  logic [1:0]   state_q, state_d;
  logic [W-1:0] period_cnt_q, period_cnt_d;
  logic [W-1:0] high_cnt_q, high_cnt_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  logic rise, fall;

  assign rise = pwm_s_q & ~pwm_d_q;
  assign fall = ~pwm_s_q & pwm_d_q;

  always_comb begin
    s1_d         = pwm_in;
    pwm_s_d      = s1_q;
    pwm_d_d      = pwm_s_q;
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    if (!ena) begin
      state_d      = StIdle;
      period_cnt_d = CntZero;
      high_cnt_d   = CntZero;
    end else begin
      case (state_q)
        StIdle: begin
          period_cnt_d = CntZero;
          high_cnt_d   = CntZero;
          // First edge only arms: there is no prior period to report.
          if (rise) begin
            state_d      = StHigh;
            period_cnt_d = CntOne;
            high_cnt_d   = CntOne;
          end
        end
        StHigh: begin
          if (period_cnt_q == CntMax) begin
            state_d      = StIdle;
            timeout_d    = 1'b1;
            period_d     = CntZero;
            duty_d       = CntMax;
            period_cnt_d = CntZero;
            high_cnt_d   = CntZero;
          end else if (fall) begin
            state_d      = StLow;
            period_cnt_d = period_cnt_q + CntOne;
          end else begin
            period_cnt_d = period_cnt_q + CntOne;
            high_cnt_d   = high_cnt_q + CntOne;
          end
        end
        StLow: begin
          // A rise on the terminal count still completes a valid measurement.
          if (rise) begin
            state_d      = StHigh;
            duty_d       = high_cnt_q;
            period_d     = period_cnt_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
            period_cnt_d = CntOne;
            high_cnt_d   = CntOne;
          end else if (period_cnt_q == CntMax) begin
            state_d      = StIdle;
            timeout_d    = 1'b1;
            period_d     = CntZero;
            duty_d       = CntZero;
            period_cnt_d = CntZero;
            high_cnt_d   = CntZero;
          end else begin
            period_cnt_d = period_cnt_q + CntOne;
          end
        end
        default: begin
          state_d      = StIdle;
          period_cnt_d = CntZero;
          high_cnt_d   = CntZero;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      pwm_s_q      <= pwm_s_d;
      pwm_d_q      <= pwm_d_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign duty_o    = duty_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign level_o   = pwm_s_q;

endmodule
